// File: rtl/fir_channel_sched_if.sv
// fir_channel_sched_if: per-channel sample handshake in, tagged result handshake out
interface fir_channel_sched_if #(
  parameter int NUM_CH = 2,
  parameter int IN_BITS = 4,
  parameter int OUT_BITS = 16,
  parameter int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0] in_valid;
  logic [NUM_CH-1:0] in_ready;
  logic [NUM_CH*IN_BITS-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [OUT_BITS-1:0] out_data;
  logic [CH_BITS-1:0] out_ch;
  modport master (
    output in_valid, in_data, out_ready,
    input in_ready, out_valid, out_data, out_ch
  );
  modport slave (
    input in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/fir_channel_sched.sv
// fir_channel_sched: round-robin serial FIR scheduler; FIR_SCHED_CLEAR_EN adds clr_valid/clr_ch history clear
module fir_channel_sched #(
  parameter int NUM_CH = 2,
  parameter int NUM_TAPS = 5,
  parameter int IN_BITS = 4,
  parameter int OUT_BITS = 16
) (
  input logic clk,
  input logic rst,
`ifdef FIR_SCHED_CLEAR_EN
  input logic clr_valid,
  input logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] clr_ch,
`endif
  fir_channel_sched_if.slave bus
);
  localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TAP_BITS = $clog2(NUM_TAPS);
  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;
  state_t state, state_n;
  logic [IN_BITS-1:0] taps [NUM_CH][NUM_TAPS];
  logic [OUT_BITS-1:0] acc, acc_n, out_data;
  logic [TAP_BITS-1:0] tap_idx;
  logic [CH_BITS-1:0] rr_ptr, cur_ch, gnt, out_ch;
  logic [NUM_CH-1:0] clr_sel;
  logic gnt_vld, accept, clr_hit, last_tap, out_valid;
  if (NUM_CH < 1 || NUM_TAPS < 2 ||
      64'(NUM_TAPS) * ((64'd1 << IN_BITS) - 64'd1) >= (64'd1 << OUT_BITS)) begin : g_param_chk
    $error("fir_channel_sched: illegal parameters or OUT_BITS too narrow for NUM_TAPS*(2^IN_BITS-1)");
  end
`ifdef FIR_SCHED_CLEAR_EN
  assign clr_hit = state == IDLE && clr_valid && int'(clr_ch) < NUM_CH;
  assign clr_sel = clr_hit ? NUM_CH'(1) << clr_ch : '0;
`else
  assign clr_hit = 1'b0;
  assign clr_sel = '0;
`endif
  always_comb begin
    gnt = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      for (int c = 0; c < NUM_CH; c++)
        if (!gnt_vld && bus.in_valid[c] && (int'(rr_ptr) + i) % NUM_CH == c) begin
          gnt = CH_BITS'(c);
          gnt_vld = 1'b1;
        end
  end
  assign accept = state == IDLE && gnt_vld && !clr_hit && !rst;
  assign bus.in_ready = accept ? NUM_CH'(1) << gnt : '0;
  assign acc_n = acc + OUT_BITS'(taps[cur_ch][tap_idx]);
  assign last_tap = tap_idx == TAP_BITS'(NUM_TAPS - 1);
  assign bus.out_valid = out_valid;
  assign bus.out_data = out_data;
  assign bus.out_ch = out_ch;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = accept ? ACCUM : IDLE;
      ACCUM: state_n = last_tap ? OUTPUT : ACCUM;
      default: state_n = bus.out_ready ? IDLE : OUTPUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      tap_idx <= '0;
      rr_ptr <= '0;
      cur_ch <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        acc <= '0;
        tap_idx <= '0;
        cur_ch <= gnt;
        rr_ptr <= (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;
      end
      if (state == ACCUM) begin
        acc <= acc_n;
        tap_idx <= tap_idx + 1'b1;
        if (last_tap) begin
          out_data <= acc_n;
          out_ch <= cur_ch;
          out_valid <= 1'b1;
        end
      end
      if (state == OUTPUT && bus.out_ready) out_valid <= 1'b0;
    end
  end
  // a channel's history moves only on its own accept, so idle channels keep theirs
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++)
      if (rst || clr_sel[c]) begin
        for (int k = 0; k < NUM_TAPS; k++) taps[c][k] <= '0;
      end else if (accept && gnt == CH_BITS'(c)) begin
        taps[c][0] <= bus.in_data[c*IN_BITS +: IN_BITS];
        for (int k = 1; k < NUM_TAPS; k++) taps[c][k] <= taps[c][k-1];
      end
  end
endmodule

// File: tb/tb_fir_channel_sched.sv
// tb_fir_channel_sched: scoreboard bench for fir_channel_sched
module tb_fir_channel_sched;
  localparam int NUM_CH = 2;
  localparam int NUM_TAPS = 5;
  localparam int IN_BITS = 4;
  localparam int OUT_BITS = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef FIR_SCHED_CLEAR_EN
  logic clr_valid = 1'b0;
  logic [0:0] clr_ch = 1'b0;
`endif
  fir_channel_sched_if #(.NUM_CH(NUM_CH), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) bus();
  fir_channel_sched #(.NUM_CH(NUM_CH), .NUM_TAPS(NUM_TAPS), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) dut (
    .clk(clk),
    .rst(rst),
`ifdef FIR_SCHED_CLEAR_EN
    .clr_valid(clr_valid),
    .clr_ch(clr_ch),
`endif
    .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [0:0] ch;
    logic [OUT_BITS-1:0] data;
  } res_t;
  res_t sb[$];
  res_t exp_r;
  int hist [NUM_CH][NUM_TAPS];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int msum;
  always @(posedge clk) cyc++;
  // reference model: tracks each channel's history on observed accepts and checks every transfer
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < NUM_TAPS; k++) hist[c][k] = 0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (bus.in_valid[c] && bus.in_ready[c]) begin
          for (int k = NUM_TAPS - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
          hist[c][0] = int'(bus.in_data[c*IN_BITS +: IN_BITS]);
          msum = 0;
          for (int k = 0; k < NUM_TAPS; k++) msum += hist[c][k];
          sb.push_back('{ch: 1'(c), data: OUT_BITS'(msum)});
        end
      if (bus.out_valid && bus.out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL out_unexpected ch=%0d data=%0d with empty scoreboard", bus.out_ch, bus.out_data);
        end else begin
          exp_r = sb.pop_front();
          if (bus.out_ch !== exp_r.ch || bus.out_data !== exp_r.data) begin
            fails++;
            $display("FAIL out_result got ch=%0d data=%0d expected ch=%0d data=%0d",
                     bus.out_ch, bus.out_data, exp_r.ch, exp_r.data);
          end
        end
      end
    end
  end
  task automatic send(input int c, input int v);
    bus.in_data[c*IN_BITS +: IN_BITS] = IN_BITS'(v);
    bus.in_valid[c] = 1'b1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (bus.in_ready[c]) begin
        @(posedge clk);
        #1 bus.in_valid[c] = 1'b0;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL send_timeout ch=%0d got no in_ready, required accept within 60 cycles", c);
    bus.in_valid[c] = 1'b0;
  endtask
  task automatic drain();
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.out_valid) return;
    end
    tests++;
    fails++;
    $display("FAIL drain_timeout pending=%0d required 0", sb.size());
  endtask
  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests += 4;
    if (bus.in_ready !== 2'b00) begin fails++; $display("FAIL reset_in_ready got %b required 00", bus.in_ready); end
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b required 0", bus.out_valid); end
    if (bus.out_data !== '0) begin fails++; $display("FAIL reset_out_data got %0d required 0", bus.out_data); end
    if (bus.out_ch !== '0) begin fails++; $display("FAIL reset_out_ch got %0d required 0", bus.out_ch); end
    bus.in_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL post_reset_out_valid got %b required 0", bus.out_valid); end
  endtask
  task automatic test_impulse();
    int lat = 0;
    send(0, 15);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    tests++;
    if (lat !== NUM_TAPS) begin fails++; $display("FAIL impulse_latency got %0d required %0d", lat, NUM_TAPS); end
    drain();
    repeat (5) begin
      send(0, 0);
      drain();
    end
  endtask
  task automatic test_step();
    repeat (6) begin
      send(1, 15);
      drain();
    end
    send(0, 3);
    drain();
  endtask
  task automatic test_round_robin();
    int got, expg, prev;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    expg = 0;
    prev = 0;
    bus.in_data = {4'd2, 4'd1};
    bus.in_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      got = -1;
      for (int n = 0; n < 40 && got < 0; n++) begin
        @(negedge clk);
        for (int c = 0; c < NUM_CH; c++) if (bus.in_ready[c]) got = c;
      end
      tests++;
      if (got !== expg) begin fails++; $display("FAIL rr_grant #%0d got ch %0d required ch %0d", i, got, expg); end
      if (i > 0) begin
        tests++;
        if (cyc - prev !== NUM_TAPS + 2) begin
          fails++;
          $display("FAIL rr_spacing #%0d got %0d cycles required %0d", i, cyc - prev, NUM_TAPS + 2);
        end
      end
      prev = cyc;
      expg = (expg + 1) % NUM_CH;
    end
    @(posedge clk);
    #1 bus.in_valid = '0;
    drain();
  endtask
  task automatic test_backpressure();
    logic [OUT_BITS-1:0] cd;
    logic [0:0] cc;
    send(0, 5);
    bus.out_ready = 1'b0;
    for (int n = 0; n < 20 && !bus.out_valid; n++) @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid got %b required 1", bus.out_valid); end
    cd = bus.out_data;
    cc = bus.out_ch;
    bus.in_data[7:4] = 4'd0;
    bus.in_valid[1] = 1'b1;
    repeat (10) begin
      @(negedge clk);
      tests += 4;
      if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid got %b required 1", bus.out_valid); end
      if (bus.out_data !== cd) begin fails++; $display("FAIL bp_hold_data got %0d required %0d", bus.out_data, cd); end
      if (bus.out_ch !== cc) begin fails++; $display("FAIL bp_hold_ch got %0d required %0d", bus.out_ch, cc); end
      if (bus.in_ready !== 2'b00) begin fails++; $display("FAIL bp_in_ready got %b required 00", bus.in_ready); end
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got %b required 0", bus.out_valid); end
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 2'b10) begin fails++; $display("FAIL bp_idle_next got in_ready %b required 10", bus.in_ready); end
    @(posedge clk);
    #1 bus.in_valid[1] = 1'b0;
    drain();
  endtask
  task automatic test_reset_mid();
    int lat = 0;
    send(0, 9);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    tests += 2;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %b required 0", bus.out_valid); end
    if (bus.out_data !== '0) begin fails++; $display("FAIL midrst_out_data got %0d required 0", bus.out_data); end
    rst = 1'b0;
    bus.in_data[3:0] = 4'd7;
    bus.in_valid[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 2'b01) begin fails++; $display("FAIL midrst_idle got in_ready %b required 01", bus.in_ready); end
    @(posedge clk);
    #1 bus.in_valid[0] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = n;
        break;
      end
    end
    tests += 2;
    if (lat !== NUM_TAPS) begin fails++; $display("FAIL midrst_latency got %0d required %0d", lat, NUM_TAPS); end
    if (bus.out_data !== 16'd7) begin fails++; $display("FAIL midrst_cleared got %0d required 7", bus.out_data); end
    drain();
  endtask
`ifdef FIR_SCHED_CLEAR_EN
  task automatic test_clear();
    repeat (5) begin
      send(0, 15);
      drain();
    end
    clr_ch = 1'b0;
    clr_valid = 1'b1;
    bus.in_data[3:0] = 4'd15;
    bus.in_valid[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 2'b00) begin fails++; $display("FAIL clr_priority got in_ready %b required 00", bus.in_ready); end
    @(posedge clk);
    #1 clr_valid = 1'b0;
    for (int k = 0; k < NUM_TAPS; k++) hist[0][k] = 0;
    send(0, 15);
    drain();
  endtask
`endif
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = '0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_impulse();
    test_step();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef FIR_SCHED_CLEAR_EN
    test_clear();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
